// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage in front of a combinational instruction memory.
// Owns the PC, captures {pc, word} into a small fetch queue and presents
// the queue head to decode over valid/ready. Redirects flush the queue; a
// misaligned redirect target queues a single exception entry and halts
// fetching until the next redirect.
// Optional build macro INST_FETCH_PERF_EN adds push and full-queue bubble
// counters (fetch_cnt_o, bubble_cnt_o).
module inst_fetch #(
    parameter int          IMEM_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [IMEM_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       pc_o,
    output logic              misalign_o
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       bubble_cnt_o
`endif
);

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    // Queue write port, shared by normal pushes and the misaligned entry
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [31:0]      wr_pc;
    logic [31:0]      wr_inst;
    logic             wr_mis;

    logic push;
    logic pop;
    logic full;

    // Queue storage; plain registers so it can be cleared by reset
    logic [31:0] pc_mem_q   [FQ_DEPTH];
    logic [31:0] inst_mem_q [FQ_DEPTH];
    logic        mis_mem_q  [FQ_DEPTH];

    // Memory address and head outputs come straight from registers
    assign imem_addr_o  = pc_q[IMEM_W-1:0];
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_mem_q[rd_ptr_q];
    assign pc_o         = pc_mem_q[rd_ptr_q];
    assign misalign_o   = mis_mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a pop never frees a slot
    // for a push in the same cycle
    assign full = (count_q == DEPTH_C);
    assign push = (state_q == ST_RUN) && !redirect_valid_i && !full;
    assign pop  = inst_valid_o && inst_ready_i && !redirect_valid_i;

    // Next-state logic: redirect overrides everything, otherwise push/pop
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        wr_en    = 1'b0;
        wr_idx   = wr_ptr_q;
        wr_pc    = pc_q;
        wr_inst  = imem_rdata_i;
        wr_mis   = 1'b0;

        if (redirect_valid_i) begin
            pc_d     = redirect_pc_i;
            rd_ptr_d = '0;
            if (redirect_pc_i[1:0] == 2'b00) begin
                state_d  = ST_RUN;
                wr_ptr_d = '0;
                count_d  = '0;
            end else begin
                // Exception entry becomes the only queue entry
                state_d  = ST_HALT;
                wr_en    = 1'b1;
                wr_idx   = '0;
                wr_pc    = redirect_pc_i;
                wr_inst  = 32'h0;
                wr_mis   = 1'b1;
                wr_ptr_d = PTR_W'(1);
                count_d  = CNT_W'(1);
            end
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State, PC and queue bookkeeping registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // One register slice per queue entry, written when selected
    for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
        // Capture the write-port data into entry gi
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pc_mem_q[gi]   <= 32'h0;
                inst_mem_q[gi] <= 32'h0;
                mis_mem_q[gi]  <= 1'b0;
            end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
                pc_mem_q[gi]   <= wr_pc;
                inst_mem_q[gi] <= wr_inst;
                mis_mem_q[gi]  <= wr_mis;
            end
        end
    end

`ifdef INST_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Count pushes and cycles lost to a full queue while fetching
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == ST_RUN) && !redirect_valid_i && full) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios followed by randomized
// ready/redirect traffic, all checked against a queue-based reference model.
module tb_inst_fetch;

    localparam int          IMEM_W   = 14;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 2;

    logic              clk_i;
    logic              rst_i;
    logic [IMEM_W-1:0] imem_addr_o;
    logic [31:0]       imem_rdata_i;
    logic              redirect_valid_i;
    logic [31:0]       redirect_pc_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [31:0]       inst_o;
    logic [31:0]       pc_o;
    logic              misalign_o;
`ifdef INST_FETCH_PERF_EN
    logic [31:0]       fetch_cnt_o;
    logic [31:0]       bubble_cnt_o;
`endif

    inst_fetch #(
        .IMEM_W   (IMEM_W),
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rdata_i     (imem_rdata_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .misalign_o       (misalign_o)
`ifdef INST_FETCH_PERF_EN
        ,
        .fetch_cnt_o      (fetch_cnt_o),
        .bubble_cnt_o     (bubble_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory contents: word at byte address a is (a/4)*0x80 + 0x13,
    // giving 0x13, 0x93, 0x113 at 0, 4, 8
    function automatic logic [31:0] mem_word(input logic [IMEM_W-1:0] a);
        logic [31:0] idx;
        idx = 32'(a) >> 2;
        return (idx << 7) + 32'h13;
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    // Reference model: a queue of fetched entries plus PC and halt flag
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_halted;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = RESET_PC;
        m_halted = 1'b0;
        m_fetch  = 32'h0;
        m_bubble = 32'h0;
    endtask

    // Advance the model by one clock edge with the currently driven inputs
    task automatic model_step();
        ent_t e;
        bit   was_full;
        bit   do_pop;
        bit   do_push;
        if (redirect_valid_i) begin
            mq.delete();
            m_pc = redirect_pc_i;
            if (redirect_pc_i[1:0] != 2'b00) begin
                e.pc   = redirect_pc_i;
                e.inst = 32'h0;
                e.mis  = 1'b1;
                mq.push_back(e);
                m_halted = 1'b1;
            end else begin
                m_halted = 1'b0;
            end
        end else begin
            was_full = (mq.size() == FQ_DEPTH);
            do_pop   = (mq.size() != 0) && inst_ready_i;
            do_push  = !m_halted && !was_full;
            if (!m_halted && was_full) m_bubble = m_bubble + 32'd1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc   = m_pc;
                e.inst = mem_word(m_pc[IMEM_W-1:0]);
                e.mis  = 1'b0;
                mq.push_back(e);
                m_pc    = m_pc + 32'd4;
                m_fetch = m_fetch + 32'd1;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(inst_valid_o), 32'(mq.size() != 0));
        check("imem_addr", 32'(imem_addr_o), 32'(m_pc[IMEM_W-1:0]));
        if (mq.size() != 0) begin
            check("inst", inst_o, mq[0].inst);
            check("pc", pc_o, mq[0].pc);
            check("misalign", 32'(misalign_o), 32'(mq[0].mis));
        end
`ifdef INST_FETCH_PERF_EN
        check("fetch_cnt", fetch_cnt_o, m_fetch);
        check("bubble_cnt", bubble_cnt_o, m_bubble);
`endif
    endtask

    // Drive one cycle of inputs, step the model, then check after the edge
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        inst_ready_i     = rdy;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'h0);
        check({tag, "_inst"}, inst_o, 32'h0);
        check({tag, "_pc"}, pc_o, 32'h0);
        check({tag, "_mis"}, 32'(misalign_o), 32'h0);
        check({tag, "_addr"}, 32'(imem_addr_o), 32'(RESET_PC[IMEM_W-1:0]));
    endtask

    // Full reset sequence ending on a falling edge with reset released
    task automatic do_reset();
        rst_i = 1'b1;
        inst_ready_i     = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_reset_outputs("rst");
        rst_i = 1'b0;
    endtask

    logic [31:0] rpc;
    logic        rdy;
    logic        rv;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Streaming from reset with decode always ready
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        check("s1_inst0", inst_o, 32'h13);
        check("s1_pc0", pc_o, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("s1_inst1", inst_o, 32'h93);
        check("s1_pc1", pc_o, 32'h4);
        cycle(1'b1, 1'b0, 32'h0);
        check("s1_inst2", inst_o, 32'h113);
        check("s1_pc2", pc_o, 32'h8);

        // Back-pressure fills the queue; PC stalls at 8
        do_reset();
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        check("s2_addr_hold", 32'(imem_addr_o), 32'h8);
        check("s2_head_pc", pc_o, 32'h0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0);

        // Redirect while the queue holds 0x10, 0x14
        cycle(1'b0, 1'b1, 32'h10);
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        check("s3_head_pc", pc_o, 32'h10);
        cycle(1'b1, 1'b1, 32'h200);
        check("s3_flush_valid", 32'(inst_valid_o), 32'h0);
        check("s3_flush_addr", 32'(imem_addr_o), 32'h200);
        cycle(1'b1, 1'b0, 32'h0);
        check("s3_new_inst", inst_o, 32'h4013);
        check("s3_new_pc", pc_o, 32'h200);

        // Misaligned redirect, drain, stay halted, recover
        cycle(1'b1, 1'b1, 32'h202);
        check("s4_mis_valid", 32'(inst_valid_o), 32'h1);
        check("s4_mis_pc", pc_o, 32'h202);
        check("s4_mis_flag", 32'(misalign_o), 32'h1);
        check("s4_mis_inst", inst_o, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);
        check("s4_halt_valid", 32'(inst_valid_o), 32'h0);
        cycle(1'b1, 1'b1, 32'h40);
        cycle(1'b1, 1'b0, 32'h0);
        check("s4_resume_pc", pc_o, 32'h40);

        // Asynchronous reset between clock edges
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("arst");
        model_reset();
        inst_ready_i     = 1'b0;
        redirect_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

`ifdef INST_FETCH_PERF_EN
        // Fill with back-pressure: 2 pushes then full-queue bubbles
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        check("perf_fetch", fetch_cnt_o, 32'd2);
        check("perf_bubble", bubble_cnt_o, 32'd3);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) rpc = rpc & 32'h0000_3FFF;
            cycle(rdy, rv, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
